// File: rtl/strela_cfg_pkg.sv
// Shared types and constants for the STRELA configuration loader.
package strela_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } cfg_loader_state_e;

  localparam int unsigned CFG_WORD_BYTES         = 4;
  localparam int unsigned CFG_FIFO_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/strela_cfg_fifo.sv
// Registered synchronous FIFO (no fall-through); head is forced to zero while empty.
module strela_cfg_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/strela_config_loader.sv
// Fetches a configuration bitstream over an OBI read port and streams it to the fabric.
// Optional STRELA_CFG_LOADER_CHECKSUM_EN adds checksum_o (XOR of the accepted words).
module strela_config_loader
  import strela_cfg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = CFG_FIFO_DEPTH_DEFAULT,
  parameter int unsigned NW_W       = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [31:0]     base_addr_i,
  input  logic [NW_W-1:0] num_words_i,
  output logic            mem_req_o,
  output logic [31:0]     mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [31:0]     mem_rdata_i,
  output logic            cfg_valid_o,
  output logic [31:0]     cfg_data_o,
  input  logic            cfg_ready_i,
  output logic            done_o,
  output logic            stall_o
`ifdef STRELA_CFG_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]     checksum_o
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  cfg_loader_state_e state_q;
  logic [31:0]       addr_q;
  logic [NW_W-1:0]   num_q, issued_q, accepted_q;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d, fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              req_hold_q, credit_ok, gnt, push, pop, start_ok;
  logic              fifo_empty, fifo_full;

  assign start_ok = (state_q == IDLE) && start_i && (num_words_i != '0);
  assign push     = mem_rvalid_i && (state_q != IDLE) && !fifo_full;
  assign pop      = cfg_valid_o && cfg_ready_i;

  // A word leaving the FIFO this cycle frees its slot, which keeps zero-wait loads at one word per cycle.
  assign credit_used = (CNT_W+1)'(outstanding_q) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop);
  assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

  assign mem_req_o  = (state_q == FETCH) && (issued_q < num_q) && (req_hold_q || credit_ok);
  assign mem_addr_o = addr_q;
  assign gnt        = mem_req_o && mem_gnt_i;
  assign stall_o    = mem_req_o && !mem_gnt_i;
  assign done_o     = (state_q == IDLE);
  assign cfg_valid_o = !fifo_empty;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({gnt, push})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      num_q         <= '0;
      issued_q      <= '0;
      accepted_q    <= '0;
      outstanding_q <= '0;
      req_hold_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      req_hold_q    <= mem_req_o && !mem_gnt_i;
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            addr_q     <= base_addr_i & 32'hFFFF_FFFC;
            num_q      <= num_words_i;
            issued_q   <= '0;
            accepted_q <= '0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (gnt) begin
            issued_q <= issued_q + 1'b1;
            addr_q   <= addr_q + 32'(CFG_WORD_BYTES);
            if (issued_q + 1'b1 == num_q) state_q <= DRAIN;
          end
          if (pop) accepted_q <= accepted_q + 1'b1;
        end
        DRAIN: begin
          if (pop) begin
            accepted_q <= accepted_q + 1'b1;
            if (accepted_q + 1'b1 == num_q) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  strela_cfg_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (mem_rdata_i),
    .pop_i   (pop),
    .rdata_o (cfg_data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

`ifdef STRELA_CFG_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       checksum_q <= '0;
    else if (start_ok) checksum_q <= '0;
    else if (pop)      checksum_q <= checksum_q ^ cfg_data_o;
  end

  assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_strela_config_loader.sv
// Randomised self-checking bench for strela_config_loader against a word-sequence model.
// Checksum scenarios are compiled in when STRELA_CFG_LOADER_CHECKSUM_EN is defined.
module tb_strela_config_loader;

  localparam int FIFO_DEPTH = 2;
  localparam int NW_W       = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic [31:0]     base_addr_i = '0;
  logic [NW_W-1:0] num_words_i = '0;
  logic            mem_req_o;
  logic [31:0]     mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i = 1'b0;
  logic [31:0]     mem_rdata_i = '0;
  logic            cfg_valid_o;
  logic [31:0]     cfg_data_o;
  logic            cfg_ready_i = 1'b0;
  logic            done_o;
  logic            stall_o;
`ifdef STRELA_CFG_LOADER_CHECKSUM_EN
  logic [31:0]     checksum_o;
`endif

  strela_config_loader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .NW_W       (NW_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .num_words_i  (num_words_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .cfg_valid_o  (cfg_valid_o),
    .cfg_data_o   (cfg_data_o),
    .cfg_ready_i  (cfg_ready_i),
    .done_o       (done_o),
    .stall_o      (stall_o)
`ifdef STRELA_CFG_LOADER_CHECKSUM_EN
    ,
    .checksum_o   (checksum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // environment knobs
  bit  resp_en = 1'b0;
  logic gnt_en = 1'b1;
  int  gnt_pct = 100, ready_pct = 100, rv_pct = 100;
  int  stall_req_idx = -1, stall_left = 0, ready_low_left = 0;

  // observations
  int  slot = 0, grants = 0, hss = 0, max_diff = 0, stall_cnt = 0, done_rise = -1;
  logic done_prev = 1'b1;
  logic [31:0] pend[$];
  logic [31:0] addr_log[$];
  logic [31:0] got[$];
  logic [31:0] stall_addrs[$];
  int          hs_slot[$];
  logic [31:0] mem_override [logic [31:0]];

  assign mem_gnt_i = mem_req_o && gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (mem_override.exists(addr)) return mem_override[addr];
    return (addr * 32'h9E37_79B1) ^ {addr[15:0], addr[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // memory responder and fabric sink, driven on the falling edge
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      pend.delete();
      mem_rvalid_i = 1'b0;
    end else if (resp_en) begin
      if (pend.size() > 0 && $urandom_range(99) < rv_pct) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(pend.pop_front());
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
      end
      if (ready_low_left > 0) begin
        cfg_ready_i = 1'b0;
        ready_low_left--;
      end else begin
        cfg_ready_i = ($urandom_range(99) < ready_pct);
      end
      if (mem_req_o && grants == stall_req_idx && stall_left > 0) begin
        gnt_en = 1'b0;
        stall_left--;
      end else begin
        gnt_en = ($urandom_range(99) < gnt_pct);
      end
    end
  end

  // monitor: samples well clear of the rising edge
  always @(negedge clk_i) begin
    #2;
    slot++;
    if (rst_ni) begin
      if (mem_req_o && mem_gnt_i) begin
        addr_log.push_back(mem_addr_o);
        pend.push_back(mem_addr_o);
        grants++;
      end
      if (stall_o) begin
        stall_cnt++;
        stall_addrs.push_back(mem_addr_o);
      end
      if (cfg_valid_o && cfg_ready_i) begin
        got.push_back(cfg_data_o);
        hs_slot.push_back(slot);
        hss++;
      end
      if (grants - hss > max_diff) max_diff = grants - hss;
      if (!done_prev && done_o) done_rise = slot;
      done_prev = done_o;
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    got.delete();
    stall_addrs.delete();
    hs_slot.delete();
    grants = 0;
    hss = 0;
    max_diff = 0;
    stall_cnt = 0;
    done_rise = -1;
  endtask

  task automatic do_load(input logic [31:0] base, input logic [NW_W-1:0] n,
                         output bit timed_out, output logic first_done, output logic first_req);
    @(negedge clk_i);
    start_i = 1'b1;
    base_addr_i = base;
    num_words_i = n;
    @(negedge clk_i);
    start_i = 1'b0;
    base_addr_i = $urandom;
    num_words_i = NW_W'($urandom);
    #3;
    first_done = done_o;
    first_req  = mem_req_o;
    timed_out  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (done_o) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk_i);
      #3;
    end
    if (timed_out) begin
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_ni = 1'b0;
    resp_en = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      start_i = 1'b1;
      num_words_i = 16'd5;
      mem_rvalid_i = 1'b1;
    end
    @(negedge clk_i);
    start_i = 1'b0;
    mem_rvalid_i = 1'b0;
    #3;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got %b want 0", mem_req_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got %h want 0", mem_addr_o); end
    total++; if (cfg_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got %b want 0", cfg_valid_o); end
    total++; if (cfg_data_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_data got %h want 0", cfg_data_o); end
    total++; if (done_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_done got %b want 1", done_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got %b want 0", stall_o); end
`ifdef STRELA_CFG_LOADER_CHECKSUM_EN
    total++; if (checksum_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_checksum got %h want 0", checksum_o); end
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    resp_en = 1'b1;
  endtask

  task automatic test_basic_load();
    bit to; logic fd, fr;
    $display("[TB] test_basic_load");
    gnt_pct = 100; ready_pct = 100; rv_pct = 100;
    clear_logs();
    do_load(32'h0000_1000, 16'd4, to, fd, fr);
    total++; if (to) begin bad++; $display("[TB] FAIL basic_timeout got timeout want done"); end
    total++; if (fd !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_t1 got %b want 0", fd); end
    total++; if (fr !== 1'b1) begin bad++; $display("[TB] FAIL basic_req_t1 got %b want 1", fr); end
    total++; if (addr_log.size() != 4) begin bad++; $display("[TB] FAIL basic_addr_count got %0d want 4", addr_log.size()); end
    total++; if (got.size() != 4) begin bad++; $display("[TB] FAIL basic_word_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      total++;
      if (addr_log[i] !== 32'h1000 + 32'(4 * i)) begin bad++; $display("[TB] FAIL basic_addr[%0d] got %h want %h", i, addr_log[i], 32'h1000 + 32'(4 * i)); end
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++;
      if (got[i] !== mem_word(32'h1000 + 32'(4 * i))) begin bad++; $display("[TB] FAIL basic_data[%0d] got %h want %h", i, got[i], mem_word(32'h1000 + 32'(4 * i))); end
    end
    if (hs_slot.size() == 4) begin
      total++; if (done_rise != hs_slot[3] + 1) begin bad++; $display("[TB] FAIL basic_done_latency got slot %0d want %0d", done_rise, hs_slot[3] + 1); end
      total++; if (hs_slot[3] - hs_slot[0] != 3) begin bad++; $display("[TB] FAIL basic_throughput got span %0d want 3", hs_slot[3] - hs_slot[0]); end
    end
  endtask

  task automatic test_grant_stall();
    bit to; logic fd, fr;
    logic [31:0] base;
    $display("[TB] test_grant_stall");
    base = {$urandom_range(32'h0FFF_FFFF), 2'b00};
    gnt_pct = 100; ready_pct = 100; rv_pct = 100;
    clear_logs();
    stall_req_idx = 1;
    stall_left = 5;
    do_load(base, 16'd4, to, fd, fr);
    stall_req_idx = -1;
    total++; if (to) begin bad++; $display("[TB] FAIL stall_timeout got timeout want done"); end
    total++; if (stall_cnt != 5) begin bad++; $display("[TB] FAIL stall_cycles got %0d want 5", stall_cnt); end
    foreach (stall_addrs[i]) begin
      total++;
      if (stall_addrs[i] !== base + 32'd4) begin bad++; $display("[TB] FAIL stall_addr[%0d] got %h want %h", i, stall_addrs[i], base + 32'd4); end
    end
    total++; if (addr_log.size() != 4) begin bad++; $display("[TB] FAIL stall_addr_count got %0d want 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      total++;
      if (addr_log[i] !== base + 32'(4 * i)) begin bad++; $display("[TB] FAIL stall_seq[%0d] got %h want %h", i, addr_log[i], base + 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    bit to; logic fd, fr;
    logic [31:0] base;
    $display("[TB] test_backpressure");
    base = {$urandom, 2'b00};
    gnt_pct = 100; ready_pct = 100; rv_pct = 100;
    clear_logs();
    ready_low_left = 20;
    do_load(base, 16'd8, to, fd, fr);
    total++; if (to) begin bad++; $display("[TB] FAIL bp_timeout got timeout want done"); end
    total++; if (max_diff > FIFO_DEPTH) begin bad++; $display("[TB] FAIL bp_in_flight got %0d want <=%0d", max_diff, FIFO_DEPTH); end
    total++; if (got.size() != 8) begin bad++; $display("[TB] FAIL bp_word_count got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      total++;
      if (got[i] !== mem_word(base + 32'(4 * i))) begin bad++; $display("[TB] FAIL bp_data[%0d] got %h want %h", i, got[i], mem_word(base + 32'(4 * i))); end
    end
  endtask

  task automatic test_edge_cases();
    bit to; logic fd, fr;
    logic [31:0] base;
    $display("[TB] test_edge_cases");
    gnt_pct = 100; ready_pct = 100; rv_pct = 100;
    // zero-length start
    clear_logs();
    do_load(32'h0000_3000, 16'd0, to, fd, fr);
    total++; if (fd !== 1'b1) begin bad++; $display("[TB] FAIL zero_done got %b want 1", fd); end
    total++; if (fr !== 1'b0) begin bad++; $display("[TB] FAIL zero_req got %b want 0", fr); end
    repeat (5) @(negedge clk_i);
    #3;
    total++; if (grants != 0) begin bad++; $display("[TB] FAIL zero_grants got %0d want 0", grants); end
    total++; if (done_o !== 1'b1) begin bad++; $display("[TB] FAIL zero_done_later got %b want 1", done_o); end
    // start pulsed mid-load
    base = {$urandom_range(32'h0FFF_FFFF), 2'b00};
    clear_logs();
    fork
      do_load(base, 16'd6, to, fd, fr);
      begin
        repeat (4) @(negedge clk_i);
        start_i = 1'b1;
        base_addr_i = 32'h0000_8000;
        num_words_i = 16'd3;
        @(negedge clk_i);
        start_i = 1'b0;
      end
    join
    total++; if (to) begin bad++; $display("[TB] FAIL midstart_timeout got timeout want done"); end
    total++; if (got.size() != 6) begin bad++; $display("[TB] FAIL midstart_count got %0d want 6", got.size()); end
    total++; if (addr_log.size() != 6) begin bad++; $display("[TB] FAIL midstart_addr_count got %0d want 6", addr_log.size()); end
    for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
      total++;
      if (addr_log[i] !== base + 32'(4 * i)) begin bad++; $display("[TB] FAIL midstart_addr[%0d] got %h want %h", i, addr_log[i], base + 32'(4 * i)); end
    end
    // address wrap
    clear_logs();
    do_load(32'hFFFF_FFFC, 16'd2, to, fd, fr);
    total++; if (addr_log.size() != 2) begin bad++; $display("[TB] FAIL wrap_count got %0d want 2", addr_log.size()); end
    if (addr_log.size() == 2) begin
      total++; if (addr_log[0] !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_addr0 got %h want fffffffc", addr_log[0]); end
      total++; if (addr_log[1] !== 32'h0000_0000) begin bad++; $display("[TB] FAIL wrap_addr1 got %h want 00000000", addr_log[1]); end
    end
    if (got.size() == 2) begin
      total++; if (got[1] !== mem_word(32'h0)) begin bad++; $display("[TB] FAIL wrap_data1 got %h want %h", got[1], mem_word(32'h0)); end
    end
  endtask

  task automatic test_reset_mid_load();
    bit to, seen_valid; logic fd, fr;
    bit reached;
    logic [31:0] base;
    $display("[TB] test_reset_mid_load");
    gnt_pct = 100; ready_pct = 100; rv_pct = 100;
    clear_logs();
    @(negedge clk_i);
    start_i = 1'b1;
    base_addr_i = 32'h0000_5000;
    num_words_i = 16'd8;
    @(negedge clk_i);
    start_i = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #3;
      if (hss >= 3) begin reached = 1'b1; break; end
      @(negedge clk_i);
    end
    total++; if (!reached) begin bad++; $display("[TB] FAIL midreset_progress got %0d words want 3", hss); end
    @(negedge clk_i);
    rst_ni = 1'b0;
    resp_en = 1'b0;
    mem_rvalid_i = 1'b0;
    pend.delete();
    #3;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL midreset_req got %b want 0", mem_req_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL midreset_addr got %h want 0", mem_addr_o); end
    total++; if (cfg_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid got %b want 0", cfg_valid_o); end
    total++; if (cfg_data_o !== 32'h0) begin bad++; $display("[TB] FAIL midreset_data got %h want 0", cfg_data_o); end
    total++; if (done_o !== 1'b1) begin bad++; $display("[TB] FAIL midreset_done got %b want 1", done_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL midreset_stall got %b want 0", stall_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cfg_ready_i = 1'b0;
    @(negedge clk_i);
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    seen_valid = 1'b0;
    repeat (4) begin
      #3;
      if (cfg_valid_o !== 1'b0) seen_valid = 1'b1;
      @(negedge clk_i);
    end
    total++; if (seen_valid) begin bad++; $display("[TB] FAIL stray_rvalid got valid=1 want valid=0"); end
    resp_en = 1'b1;
    base = {$urandom, 2'b00};
    clear_logs();
    do_load(base, 16'd2, to, fd, fr);
    total++; if (to) begin bad++; $display("[TB] FAIL postreset_timeout got timeout want done"); end
    total++; if (got.size() != 2) begin bad++; $display("[TB] FAIL postreset_count got %0d want 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      total++;
      if (got[i] !== mem_word(base + 32'(4 * i))) begin bad++; $display("[TB] FAIL postreset_data[%0d] got %h want %h", i, got[i], mem_word(base + 32'(4 * i))); end
    end
  endtask

  task automatic test_random_loads();
    bit to; logic fd, fr;
    logic [31:0] base, aligned, expw;
    int n;
    $display("[TB] test_random_loads");
    for (int it = 0; it < 10; it++) begin
      base = $urandom;
      aligned = base & 32'hFFFF_FFFC;
      n = $urandom_range(1, 12);
      gnt_pct = $urandom_range(40, 100);
      ready_pct = $urandom_range(30, 100);
      rv_pct = $urandom_range(40, 100);
      clear_logs();
      do_load(base, NW_W'(n), to, fd, fr);
      total++; if (to) begin bad++; $display("[TB] FAIL rand%0d_timeout got timeout want done", it); end
      total++; if (got.size() != n) begin bad++; $display("[TB] FAIL rand%0d_count got %0d want %0d", it, got.size(), n); end
      total++; if (max_diff > FIFO_DEPTH) begin bad++; $display("[TB] FAIL rand%0d_in_flight got %0d want <=%0d", it, max_diff, FIFO_DEPTH); end
      expw = '0;
      for (int i = 0; i < n; i++) begin
        expw = expw ^ mem_word(aligned + 32'(4 * i));
        if (i < addr_log.size()) begin
          total++;
          if (addr_log[i] !== aligned + 32'(4 * i)) begin bad++; $display("[TB] FAIL rand%0d_addr[%0d] got %h want %h", it, i, addr_log[i], aligned + 32'(4 * i)); end
        end
        if (i < got.size()) begin
          total++;
          if (got[i] !== mem_word(aligned + 32'(4 * i))) begin bad++; $display("[TB] FAIL rand%0d_data[%0d] got %h want %h", it, i, got[i], mem_word(aligned + 32'(4 * i))); end
        end
      end
`ifdef STRELA_CFG_LOADER_CHECKSUM_EN
      total++; if (checksum_o !== expw) begin bad++; $display("[TB] FAIL rand%0d_checksum got %h want %h", it, checksum_o, expw); end
`endif
    end
    gnt_pct = 100; ready_pct = 100; rv_pct = 100;
  endtask

`ifdef STRELA_CFG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit to; logic fd, fr;
    logic [31:0] words [3];
    logic [31:0] expw;
    $display("[TB] test_checksum");
    words[0] = 32'hA5A5_A5A5;
    words[1] = 32'h0F0F_0F0F;
    words[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) mem_override[32'h2000 + 32'(4 * i)] = words[i];
    for (int n = 2; n <= 3; n++) begin
      expw = '0;
      for (int i = 0; i < n; i++) expw = expw ^ words[i];
      clear_logs();
      do_load(32'h0000_2000, NW_W'(n), to, fd, fr);
      total++; if (to) begin bad++; $display("[TB] FAIL cks%0d_timeout got timeout want done", n); end
      total++; if (checksum_o !== expw) begin bad++; $display("[TB] FAIL cks%0d_value got %h want %h", n, checksum_o, expw); end
    end
    mem_override.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_grant_stall();
    test_backpressure();
    test_edge_cases();
    test_reset_mid_load();
    test_random_loads();
`ifdef STRELA_CFG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
